// File: rtl/uart_alu_ctrl_if.sv
// Bus between the UART/ALU sequencing controller and its surroundings:
// receiver bytes in, ALU operands out, ALU result in, transmitter byte out, status out.
interface uart_alu_ctrl_if #(
    parameter int OPERAND_SIZE = 8,
    parameter int OP_CODE_SIZE = 6
);
    logic [OPERAND_SIZE-1:0] i_rx_data;
    logic                    i_rx_done;
    logic [OPERAND_SIZE-1:0] o_dato_a;
    logic [OPERAND_SIZE-1:0] o_dato_b;
    logic [OP_CODE_SIZE-1:0] o_op_code;
    logic [OPERAND_SIZE-1:0] i_resultado;
    logic [OPERAND_SIZE-1:0] o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_done;
    logic                    o_busy;
    logic                    o_err;
    logic [1:0]              o_err_code;

    modport master (
        input  i_rx_data, i_rx_done, i_resultado, i_tx_done,
        output o_dato_a, o_dato_b, o_op_code, o_tx_data, o_tx_start,
               o_busy, o_err, o_err_code
    );

    modport slave (
        output i_rx_data, i_rx_done, i_resultado, i_tx_done,
        input  o_dato_a, o_dato_b, o_op_code, o_tx_data, o_tx_start,
               o_busy, o_err, o_err_code
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Assembles A, B and opcode bytes from the UART receiver, drives the ALU,
// and returns the registered result byte to the UART transmitter.
module uart_alu_ctrl #(
    parameter int          OPERAND_SIZE   = 8,
    parameter int          OP_CODE_SIZE   = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_alu_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        SEND,
        WAIT_TX
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_OPCODE  = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_t;

    localparam logic [OPERAND_SIZE-1:0] OP_ADD = OPERAND_SIZE'(8'h20);
    localparam logic [OPERAND_SIZE-1:0] OP_SUB = OPERAND_SIZE'(8'h22);
    localparam logic [OPERAND_SIZE-1:0] OP_AND = OPERAND_SIZE'(8'h24);
    localparam logic [OPERAND_SIZE-1:0] OP_OR  = OPERAND_SIZE'(8'h25);
    localparam logic [OPERAND_SIZE-1:0] OP_XOR = OPERAND_SIZE'(8'h26);
    localparam logic [OPERAND_SIZE-1:0] OP_NOR = OPERAND_SIZE'(8'h27);
    localparam logic [OPERAND_SIZE-1:0] OP_03  = OPERAND_SIZE'(8'h03);
    localparam logic [OPERAND_SIZE-1:0] OP_02  = OPERAND_SIZE'(8'h02);
    localparam logic [OPERAND_SIZE-1:0] OP_CLR = OPERAND_SIZE'(8'h00);

    // The counter never needs to hold TIMEOUT_CYCLES itself: the error fires
    // on the idle edge that would take it there.
    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic             op_valid;
    logic             timeout_hit;
    logic             in_gap;
    logic             in_flight;

    always_comb begin
        op_valid = 1'b0;
        case (bus.i_rx_data)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOR, OP_03, OP_02, OP_CLR: op_valid = 1'b1;
            default:                      op_valid = 1'b0;
        endcase
    end

    always_comb begin
        in_gap      = (state == WAIT_B) || (state == WAIT_OP);
        in_flight   = (state == CALC) || (state == SEND) || (state == WAIT_TX);
        timeout_hit = TIMEOUT_EN && (idle_cnt == CNT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= WAIT_A;
            idle_cnt       <= '0;
            bus.o_dato_a   <= '0;
            bus.o_dato_b   <= '0;
            bus.o_op_code  <= '0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_err      <= 1'b0;
            bus.o_err_code <= ERR_NONE;
        end else begin
            bus.o_err      <= 1'b0;
            bus.o_tx_start <= 1'b0;

            case (state)
                WAIT_A: begin
                    if (bus.i_rx_done) begin
                        bus.o_dato_a <= bus.i_rx_data;
                        idle_cnt     <= '0;
                        state        <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_done) begin
                        bus.o_dato_b <= bus.i_rx_data;
                        idle_cnt     <= '0;
                        state        <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        idle_cnt <= '0;
                        if (op_valid) begin
                            bus.o_op_code <= bus.i_rx_data[OP_CODE_SIZE-1:0];
                            bus.o_busy    <= 1'b1;
                            state         <= CALC;
                        end else begin
                            bus.o_err      <= 1'b1;
                            bus.o_err_code <= ERR_OPCODE;
                            state          <= WAIT_A;
                        end
                    end
                end
                CALC: begin
                    bus.o_tx_data <= bus.i_resultado;
                    state         <= SEND;
                end
                SEND: begin
                    bus.o_tx_start <= 1'b1;
                    state          <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        bus.o_busy <= 1'b0;
                        state      <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase

            // Received byte takes priority over an expiring timeout.
            if (in_gap && !bus.i_rx_done) begin
                if (timeout_hit) begin
                    bus.o_err      <= 1'b1;
                    bus.o_err_code <= ERR_TIMEOUT;
                    idle_cnt       <= '0;
                    state          <= WAIT_A;
                end else if (TIMEOUT_EN) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            if (in_flight && bus.i_rx_done) begin
                bus.o_err      <= 1'b1;
                bus.o_err_code <= ERR_OVERRUN;
            end
        end
    end

endmodule
